// File: rtl/loader_pkg.sv
// Shared types for the ioctl-to-SDRAM ROM loader: FSM states, FIFO entry layout
// and byte-enable codes.
package loader_pkg;

  // Widest word address ioctl can produce (27-bit byte address -> 26-bit word).
  localparam int WORD_ADDR_MAX_W = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_BOTH = 2'b11;

  typedef struct packed {
    logic [WORD_ADDR_MAX_W-1:0] addr;
    logic [15:0]                data;
    logic [1:0]                 be;
  } fifo_entry_t;

  function automatic fifo_entry_t make_entry(input logic [WORD_ADDR_MAX_W-1:0] addr,
                                             input logic [15:0] data,
                                             input logic [1:0] be);
    fifo_entry_t e;
    e.addr = addr;
    e.data = data;
    e.be   = be;
    return e;
  endfunction

endpackage

// File: rtl/ioctl_sdram_loader_if.sv
// SDRAM write port between the loader (master) and the memory controller (slave):
// level request, one-cycle ack.
interface ioctl_sdram_loader_if #(
  parameter int ADDR_W = 24
);
  logic              sdram_req;
  logic              sdram_ack;
  logic [ADDR_W-1:0] sdram_addr;
  logic [15:0]       sdram_din;
  logic [1:0]        sdram_be;

  modport master (
    output sdram_req,
    output sdram_addr,
    output sdram_din,
    output sdram_be,
    input  sdram_ack
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    input  sdram_din,
    input  sdram_be,
    output sdram_ack
  );
endinterface

// File: rtl/loader_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible combinationally so the
// caller can register it in the same cycle it pops.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = fifo_entry_t
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered count, so a push into a full FIFO is
  // refused even if a pop happens in the same cycle.
  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Packs the MiST ioctl byte stream into 16-bit SDRAM writes and holds the core in
// reset until the image is committed. Build option LOADER_CHECKSUM_EN adds a byte sum.
module ioctl_sdram_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W     = 24,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ROM_INDEX  = 8'd0
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        ioctl_download,
  input  logic [7:0]                  ioctl_index,
  input  logic                        ioctl_wr,
  input  logic [26:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  ioctl_sdram_loader_if.master        sdram,
  output logic                        busy,
  output logic                        done,
  output logic                        core_reset,
  output logic                        overflow,
  output logic [15:0]                 checksum
);

  state_t              state_reg, state_next;
  logic                download_q_reg;
  logic                dl_rise, dl_fall, start_hit, accept;
  logic [ADDR_W-1:0]   byte_word;

  logic                pend_reg, pend_next;
  logic [7:0]          pend_byte_reg, pend_byte_next;
  logic [ADDR_W-1:0]   pend_addr_reg, pend_addr_next;

  logic                push_valid;
  fifo_entry_t         push_entry;
  fifo_entry_t         fifo_head;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic                req_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [15:0]         din_reg;
  logic [1:0]          be_reg;
  logic                overflow_reg;

  assign dl_rise   = ioctl_download && !download_q_reg;
  assign dl_fall   = !ioctl_download && download_q_reg;
  assign start_hit = dl_rise && (ioctl_index == ROM_INDEX) &&
                     ((state_reg == IDLE) || (state_reg == DONE));
  assign accept    = (state_reg == LOAD) && ioctl_wr && ioctl_download;
  assign byte_word = ioctl_addr[ADDR_W:1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      download_q_reg <= 1'b0;
      pend_reg       <= 1'b0;
      pend_byte_reg  <= 8'h00;
      pend_addr_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      download_q_reg <= ioctl_download;
      pend_reg       <= pend_next;
      pend_byte_reg  <= pend_byte_next;
      pend_addr_reg  <= pend_addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_hit) state_next = LOAD;
      LOAD:    if (dl_fall) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !req_reg && !pend_reg) state_next = DONE;
      DONE:    if (start_hit) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // At most one push per cycle. An odd byte that does not complete the pending
  // even byte goes out alone and leaves the pending byte for a later flush.
  always_comb begin
    push_valid     = 1'b0;
    push_entry     = '0;
    pend_next      = pend_reg;
    pend_byte_next = pend_byte_reg;
    pend_addr_next = pend_addr_reg;
    if (start_hit) begin
      pend_next = 1'b0;
    end else if (accept) begin
      if (ioctl_addr[0]) begin
        push_valid = 1'b1;
        if (pend_reg && (pend_addr_reg == byte_word)) begin
          push_entry = make_entry(WORD_ADDR_MAX_W'(byte_word), {ioctl_dout, pend_byte_reg}, BE_BOTH);
          pend_next  = 1'b0;
        end else begin
          push_entry = make_entry(WORD_ADDR_MAX_W'(byte_word), {ioctl_dout, 8'h00}, BE_HI);
        end
      end else begin
        if (pend_reg) begin
          push_valid = 1'b1;
          push_entry = make_entry(WORD_ADDR_MAX_W'(pend_addr_reg), {8'h00, pend_byte_reg}, BE_LO);
        end
        pend_next      = 1'b1;
        pend_byte_next = ioctl_dout;
        pend_addr_next = byte_word;
      end
    end else if ((state_reg == LOAD) && dl_fall && pend_reg) begin
      push_valid = 1'b1;
      push_entry = make_entry(WORD_ADDR_MAX_W'(pend_addr_reg), {8'h00, pend_byte_reg}, BE_LO);
      pend_next  = 1'b0;
    end
  end

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fifo_entry_t)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Popping only while the port is idle guarantees a low cycle between requests.
  assign fifo_pop = !req_reg && !fifo_empty;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req_reg  <= 1'b0;
      addr_reg <= '0;
      din_reg  <= 16'h0000;
      be_reg   <= 2'b00;
    end else if (fifo_pop) begin
      req_reg  <= 1'b1;
      addr_reg <= fifo_head.addr[ADDR_W-1:0];
      din_reg  <= fifo_head.data;
      be_reg   <= fifo_head.be;
    end else if (req_reg && sdram.sdram_ack) begin
      req_reg  <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
    end else if (start_hit) begin
      overflow_reg <= 1'b0;
    end else if (push_valid && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_reg;

  // Every accepted byte is summed, including ones the FIFO later drops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum_reg <= 16'h0000;
    end else if (start_hit) begin
      checksum_reg <= 16'h0000;
    end else if (accept) begin
      checksum_reg <= checksum_reg + {8'h00, ioctl_dout};
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'h0000;
`endif

  assign sdram.sdram_req  = req_reg;
  assign sdram.sdram_addr = addr_reg;
  assign sdram.sdram_din  = din_reg;
  assign sdram.sdram_be   = be_reg;

  assign busy       = (state_reg == LOAD) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);
  assign core_reset = (state_reg != DONE);
  assign overflow   = overflow_reg;

  // Address bits above ADDR_W are discarded by design; the count is informational.
  logic unused_ok;
  assign unused_ok = ^{ioctl_addr, fifo_head, fifo_count};

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: drives ioctl downloads, models an SDRAM
// controller that acks after a fixed delay, and checks the committed words.
module tb_ioctl_sdram_loader;

  logic        clk_sys        = 1'b0;
  logic        reset_n        = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index    = 8'd0;
  logic        ioctl_wr       = 1'b0;
  logic [26:0] ioctl_addr     = 27'd0;
  logic [7:0]  ioctl_dout     = 8'd0;
  logic        busy, done, core_reset, overflow;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [15:0] CK_OVF = 16'h030C;
  localparam logic [15:0] CK_FF  = 16'h02FD;
`else
  localparam logic [15:0] CK_OVF = 16'h0000;
  localparam logic [15:0] CK_FF  = 16'h0000;
`endif

  ioctl_sdram_loader_if #(.ADDR_W(24)) bus ();

  ioctl_sdram_loader #(
    .ADDR_W     (24),
    .FIFO_DEPTH (8),
    .ROM_INDEX  (8'd0)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .sdram          (bus),
    .busy           (busy),
    .done           (done),
    .core_reset     (core_reset),
    .overflow       (overflow),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acks ack_delay negedges after the request is first seen.
  logic [41:0] log_q [$];
  bit          done_q [$];
  int          req_cnt   = 0;
  int          ack_delay = 2;
  bit          ack_en    = 1'b1;

  initial begin
    int  wait_cnt;
    bit  req_prev;
    wait_cnt = 0;
    req_prev = 1'b0;
    bus.sdram_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (bus.sdram_req === 1'b1 && !req_prev) req_cnt++;
      req_prev = (bus.sdram_req === 1'b1);
      if (bus.sdram_ack) begin
        bus.sdram_ack = 1'b0;
        wait_cnt = 0;
      end else if (bus.sdram_req === 1'b1 && ack_en) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          bus.sdram_ack = 1'b1;
          log_q.push_back({bus.sdram_addr, bus.sdram_din, bus.sdram_be});
          done_q.push_back(done);
          $display("txn addr=%06h din=%04h be=%b", bus.sdram_addr, bus.sdram_din, bus.sdram_be);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_q.delete();
    done_q.delete();
    req_cnt = 0;
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (n < 500 && done !== 1'b1) begin
      @(negedge clk_sys);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({bus.sdram_req, bus.sdram_be, busy, done, core_reset, overflow} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000010",
               {bus.sdram_req, bus.sdram_be, busy, done, core_reset, overflow});
    end
    checks++;
    if ({bus.sdram_addr, bus.sdram_din, checksum} !== 56'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h din=%h ck=%h expected all zero",
               bus.sdram_addr, bus.sdram_din, checksum);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_wrong_index();
    clear_log();
    start_dl(8'd3);
    send_byte(27'd0, 8'h12);
    send_byte(27'd1, 8'h34);
    end_dl();
    repeat (5) @(negedge clk_sys);
    checks++;
    if (req_cnt != 0 || bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL wrong_index_req: got %0d requests req=%b expected none", req_cnt, bus.sdram_req);
    end
    checks++;
    if ({busy, done, core_reset} !== 3'b001) begin
      errors++;
      $display("FAIL wrong_index_state: got busy/done/core_reset=%b expected 001", {busy, done, core_reset});
    end
  endtask

  task automatic test_basic();
    logic [41:0] exp [2];
    bit ok;
    exp[0] = {24'd0, 16'h2211, 2'b11};
    exp[1] = {24'd1, 16'h4433, 2'b11};
    clear_log();
    start_dl(8'd0);
    checks++;
    if ({busy, done, core_reset} !== 3'b101) begin
      errors++;
      $display("FAIL basic_load_state: got %b expected 101", {busy, done, core_reset});
    end
    send_byte(27'd0, 8'h11);
    ioctl_addr = 27'd1;
    ioctl_dout = 8'h22;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    checks++;
    if (bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_n1: got req=%b expected 0", bus.sdram_req);
    end
    @(negedge clk_sys);
    checks++;
    if (bus.sdram_req !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency_n2: got req=%b expected 1", bus.sdram_req);
    end
    send_byte(27'd2, 8'h33);
    send_byte(27'd3, 8'h44);
    end_dl();
    wait_done(ok);
    checks++;
    if (!ok || {done, core_reset, busy} !== 3'b100) begin
      errors++;
      $display("FAIL basic_done: got done/core_reset/busy=%b expected 100", {done, core_reset, busy});
    end
    checks++;
    if (log_q.size() != 2 || req_cnt != 2) begin
      errors++;
      $display("FAIL basic_count: got %0d words %0d requests expected 2 2", log_q.size(), req_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 42'h0, exp[i]);
      end
    end
  endtask

  task automatic test_odd_length();
    logic [41:0] exp [2];
    bit ok;
    exp[0] = {24'd0, 16'hBBAA, 2'b11};
    exp[1] = {24'd1, 16'h00CC, 2'b01};
    clear_log();
    start_dl(8'd0);
    checks++;
    if ({busy, done, core_reset} !== 3'b101) begin
      errors++;
      $display("FAIL odd_restart_state: got %b expected 101", {busy, done, core_reset});
    end
    send_byte(27'd0, 8'hAA);
    send_byte(27'd1, 8'hBB);
    send_byte(27'd2, 8'hCC);
    end_dl();
    wait_done(ok);
    checks++;
    if (!ok || log_q.size() != 2) begin
      errors++;
      $display("FAIL odd_count: got done=%b words=%0d expected 1 2", done, log_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL odd_word%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 42'h0, exp[i]);
      end
    end
    checks++;
    if (done_q.size() != 2 || done_q[1] != 1'b0) begin
      errors++;
      $display("FAIL odd_done_before_ack: done at last ack was %b expected 0",
               (done_q.size() == 2) ? done_q[1] : 1'b1);
    end
  endtask

  task automatic test_pack_cases();
    logic [41:0] exp [3];
    bit ok;
    exp[0] = {24'd2, 16'h0055, 2'b01};
    exp[1] = {24'd3, 16'h7766, 2'b11};
    exp[2] = {24'd4, 16'h8800, 2'b10};
    clear_log();
    start_dl(8'd0);
    send_byte(27'd4, 8'h55);
    send_byte(27'd6, 8'h66);
    send_byte(27'd7, 8'h77);
    send_byte(27'd9, 8'h88);
    end_dl();
    wait_done(ok);
    checks++;
    if (!ok || log_q.size() != 3 || req_cnt != 3) begin
      errors++;
      $display("FAIL pack_count: got done=%b words=%0d requests=%0d expected 1 3 3", done, log_q.size(), req_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL pack_word%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 42'h0, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [41:0] expw;
    bit ok;
    clear_log();
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int k = 0; k < 20; k++) begin
      send_byte(27'(2 * k), 8'(2 * k));
      send_byte(27'(2 * k + 1), 8'(2 * k + 1));
    end
    checks++;
    if (overflow !== 1'b1 || bus.sdram_req !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got overflow=%b req=%b expected 1 1", overflow, bus.sdram_req);
    end
    end_dl();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_drain_hold: got busy/done=%b expected 10", {busy, done});
    end
    ack_en = 1'b1;
    wait_done(ok);
    checks++;
    if (!ok || log_q.size() != 9) begin
      errors++;
      $display("FAIL ovf_count: got done=%b words=%0d expected 1 9", done, log_q.size());
    end
    for (int k = 0; k < 9; k++) begin
      expw = {24'(k), 8'(2 * k + 1), 8'(2 * k), 2'b11};
      checks++;
      if (k >= log_q.size() || log_q[k] !== expw) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h expected %h", k, (k < log_q.size()) ? log_q[k] : 42'h0, expw);
      end
    end
    checks++;
    if (checksum !== CK_OVF) begin
      errors++;
      $display("FAIL ovf_checksum: got %h expected %h", checksum, CK_OVF);
    end
    start_dl(8'd0);
    checks++;
    if (overflow !== 1'b0 || checksum !== 16'h0000) begin
      errors++;
      $display("FAIL ovf_clear: got overflow=%b checksum=%h expected 0 0000", overflow, checksum);
    end
    end_dl();
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_empty_done: got done=%b expected 1", done);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    clear_log();
    ack_en = 1'b0;
    start_dl(8'd0);
    send_byte(27'd0, 8'h01);
    send_byte(27'd1, 8'h02);
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_din !== 16'h0201) begin
      errors++;
      $display("FAIL rst_pre_req: got req=%b din=%h expected 1 0201", bus.sdram_req, bus.sdram_din);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.sdram_req, busy, done, core_reset} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_async: got req/busy/done/core_reset=%b expected 0001",
               {bus.sdram_req, busy, done, core_reset});
    end
    checks++;
    if (bus.sdram_din !== 16'h0000) begin
      errors++;
      $display("FAIL rst_din: got %h expected 0000", bus.sdram_din);
    end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    @(negedge clk_sys);
    clear_log();
    start_dl(8'd0);
    send_byte(27'd0, 8'hA1);
    send_byte(27'd1, 8'hB2);
    end_dl();
    wait_done(ok);
    checks++;
    if (!ok || log_q.size() != 1) begin
      errors++;
      $display("FAIL rst_reload_count: got done=%b words=%0d expected 1 1", done, log_q.size());
    end
    checks++;
    if (log_q.size() < 1 || log_q[0] !== {24'd0, 16'hB2A1, 2'b11}) begin
      errors++;
      $display("FAIL rst_reload_word: got %h expected %h",
               (log_q.size() > 0) ? log_q[0] : 42'h0, {24'd0, 16'hB2A1, 2'b11});
    end
  endtask

  task automatic test_checksum();
    bit ok;
    clear_log();
    start_dl(8'd0);
    send_byte(27'd0, 8'hFF);
    send_byte(27'd1, 8'hFF);
    send_byte(27'd2, 8'hFF);
    end_dl();
    wait_done(ok);
    checks++;
    if (!ok || checksum !== CK_FF) begin
      errors++;
      $display("FAIL checksum_ff: got done=%b checksum=%h expected 1 %h", done, checksum, CK_FF);
    end
    checks++;
    if (log_q.size() != 2 || log_q[0] !== {24'd0, 16'hFFFF, 2'b11} || log_q[1] !== {24'd1, 16'h00FF, 2'b01}) begin
      errors++;
      $display("FAIL checksum_words: got %0d words first=%h expected 2 words %h",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 42'h0, {24'd0, 16'hFFFF, 2'b11});
    end
  endtask

  initial begin
    test_reset();
    test_wrong_index();
    test_basic();
    test_odd_length();
    test_pack_cases();
    test_overflow();
    test_reset_mid_load();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
